// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_capture
// Purpose  : Receive end of a multiplexed 7-segment scan bus. Demultiplexes
//            the time-shared {en_seg, data_seg, dt} bus into per-digit
//            registers, deglitches each scan slot, flags stale digits and
//            reports malformed (multi-low) enables.
// Ports    : FPGA_CLK      system clock, rising edge
//            FPGA_RST      synchronous reset, active-high
//            en_seg        digit enables, active-low
//            data_seg      digit value on the bus
//            dt            decimal-point bit on the bus
//            digits        captured values, digit i at [i*DATA_W +: DATA_W]
//            dp            captured decimal point per digit
//            digit_valid   digit committed at least once and not stale
//            timeout       sticky stale flag per digit
//            update_pulse  1-cycle strobe when a committed value changed
//            upd_idx       digit index qualifying update_pulse
//            scan_err      1-cycle strobe per sample with >1 enable low
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_capture #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 4,
    parameter int STABLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 1024,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                         FPGA_CLK,
    input  logic                         FPGA_RST,
    input  logic [NUM_DIGITS-1:0]        en_seg,
    input  logic [DATA_W-1:0]            data_seg,
    input  logic                         dt,
    output logic [NUM_DIGITS*DATA_W-1:0] digits,
    output logic [NUM_DIGITS-1:0]        dp,
    output logic [NUM_DIGITS-1:0]        digit_valid,
    output logic [NUM_DIGITS-1:0]        timeout,
    output logic                         update_pulse,
    output logic [IDX_W-1:0]             upd_idx,
    output logic                         scan_err
);

    localparam int c_TUP_W   = NUM_DIGITS + DATA_W + 1;
    localparam int c_VAL_W   = DATA_W + 1;
    localparam int c_CNT_MAX = STABLE_CYC + 1;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_STALE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int c_ZERO_W  = $clog2(NUM_DIGITS + 1);

    // Sampled tuple and the one before it; the valid bits keep the cleared
    // reset contents from being classified as a real (all-low) enable.
    logic [c_TUP_W-1:0]        r_samp;
    logic [c_TUP_W-1:0]        r_prev;
    logic                      r_samp_vld;
    logic                      r_prev_vld;
    logic [c_CNT_W-1:0]        r_cnt;

    logic [NUM_DIGITS*DATA_W-1:0] r_digits;
    logic [NUM_DIGITS-1:0]        r_dp;
    logic [NUM_DIGITS-1:0]        r_valid;
    logic [NUM_DIGITS-1:0]        r_timeout;
    logic                         r_upd;
    logic [IDX_W-1:0]             r_upd_idx;
    logic                         r_scan_err;
    logic [c_STALE_W-1:0]         r_stale [NUM_DIGITS];

    logic [NUM_DIGITS-1:0] w_samp_en;
    logic [c_VAL_W-1:0]    w_samp_val;
    logic [c_ZERO_W-1:0]   w_zeros;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_legal;
    logic                  w_illegal;
    logic                  w_same;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_commit;
    logic [c_VAL_W-1:0]    w_old_val;
    logic                  w_changed;

    assign w_samp_en  = r_samp[c_TUP_W-1 -: NUM_DIGITS];
    assign w_samp_val = r_samp[c_VAL_W-1:0];

    // Count low enables; w_idx is only meaningful when exactly one is low.
    always_comb begin
        w_zeros = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!w_samp_en[i]) begin
                w_zeros = w_zeros + c_ZERO_W'(1);
                w_idx   = IDX_W'(i);
            end
        end
    end

    assign w_legal   = r_samp_vld && (w_zeros == c_ZERO_W'(1));
    assign w_illegal = r_samp_vld && (w_zeros >  c_ZERO_W'(1));
    assign w_same    = r_prev_vld && (r_samp == r_prev);

    // Dwell counter saturates one past STABLE_CYC so the commit fires once.
    always_comb begin
        w_cnt_nxt = '0;
        if (w_legal) begin
            if (!w_same)
                w_cnt_nxt = c_CNT_W'(1);
            else if (r_cnt == c_CNT_W'(c_CNT_MAX))
                w_cnt_nxt = r_cnt;
            else
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
    end

    assign w_commit  = w_legal && (w_cnt_nxt == c_CNT_W'(STABLE_CYC));
    assign w_old_val = {r_digits[w_idx*DATA_W +: DATA_W], r_dp[w_idx]};
    assign w_changed = (w_old_val != w_samp_val) || !r_valid[w_idx];

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            r_samp     <= '0;
            r_prev     <= '0;
            r_samp_vld <= 1'b0;
            r_prev_vld <= 1'b0;
            r_cnt      <= '0;
            r_digits   <= '0;
            r_dp       <= '0;
            r_valid    <= '0;
            r_timeout  <= '0;
            r_upd      <= 1'b0;
            r_upd_idx  <= '0;
            r_scan_err <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++)
                r_stale[i] <= '0;
        end else begin
            r_samp     <= {en_seg, data_seg, dt};
            r_samp_vld <= 1'b1;
            r_prev     <= r_samp;
            r_prev_vld <= r_samp_vld;
            r_cnt      <= w_cnt_nxt;
            r_scan_err <= w_illegal;
            r_upd      <= w_commit && w_changed;
            if (w_commit && w_changed)
                r_upd_idx <= w_idx;

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_commit && (w_idx == IDX_W'(i))) begin
                    // A commit wins over a stale threshold in the same cycle.
                    r_digits[i*DATA_W +: DATA_W] <= w_samp_val[c_VAL_W-1:1];
                    r_dp[i]      <= w_samp_val[0];
                    r_valid[i]   <= 1'b1;
                    r_timeout[i] <= 1'b0;
                    r_stale[i]   <= '0;
                end else begin
                    if (r_stale[i] != c_STALE_W'(TIMEOUT_CYC))
                        r_stale[i] <= r_stale[i] + c_STALE_W'(1);
                    if (r_stale[i] >= c_STALE_W'(TIMEOUT_CYC - 1)) begin
                        r_valid[i]   <= 1'b0;
                        r_timeout[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign digits       = r_digits;
    assign dp           = r_dp;
    assign digit_valid  = r_valid;
    assign timeout      = r_timeout;
    assign update_pulse = r_upd;
    assign upd_idx      = r_upd_idx;
    assign scan_err     = r_scan_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_capture
// Purpose  : Self-checking bench for seg_scan_capture. Two instances:
//            u_dut1 (STABLE_CYC=1) and u_dut3 (STABLE_CYC=3), both with
//            TIMEOUT_CYC=16. Expected update events go into per-instance
//            queues; a monitor pops them whenever update_pulse is seen.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3;
    logic [3:0]  en1, en3, d1, d3;
    logic        dt1, dt3;
    logic [15:0] dg1, dg3;
    logic [3:0]  dp1, dp3, vl1, vl3, to1, to3;
    logic        up1, up3, se1, se3;
    logic [1:0]  ix1, ix3;

    seg_scan_capture #(.NUM_DIGITS(4), .DATA_W(4), .STABLE_CYC(1), .TIMEOUT_CYC(16)) u_dut1 (
        .FPGA_CLK(clk), .FPGA_RST(rst1), .en_seg(en1), .data_seg(d1), .dt(dt1),
        .digits(dg1), .dp(dp1), .digit_valid(vl1), .timeout(to1),
        .update_pulse(up1), .upd_idx(ix1), .scan_err(se1));

    seg_scan_capture #(.NUM_DIGITS(4), .DATA_W(4), .STABLE_CYC(3), .TIMEOUT_CYC(16)) u_dut3 (
        .FPGA_CLK(clk), .FPGA_RST(rst3), .en_seg(en3), .data_seg(d3), .dt(dt3),
        .digits(dg3), .dp(dp3), .digit_valid(vl3), .timeout(to3),
        .update_pulse(up3), .upd_idx(ix3), .scan_err(se3));

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] data;
        logic       dp;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   se_cnt1  = 0;
    int   se_cnt3  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sample 2 time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (up1) begin
                if (q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL dut1_unexpected_update: got idx %0d expected no update", ix1);
                end else begin
                    e = q1.pop_front();
                    check("dut1_upd_idx",  {30'd0, ix1}, {30'd0, e.idx});
                    check("dut1_upd_data", {28'd0, dg1[ix1*4 +: 4]}, {28'd0, e.data});
                    check("dut1_upd_dp",   {31'd0, dp1[ix1]}, {31'd0, e.dp});
                end
            end
            if (up3) begin
                if (q3.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL dut3_unexpected_update: got idx %0d expected no update", ix3);
                end else begin
                    e = q3.pop_front();
                    check("dut3_upd_idx",  {30'd0, ix3}, {30'd0, e.idx});
                    check("dut3_upd_data", {28'd0, dg3[ix3*4 +: 4]}, {28'd0, e.data});
                    check("dut3_upd_dp",   {31'd0, dp3[ix3]}, {31'd0, e.dp});
                end
            end
            if (se1) se_cnt1++;
            if (se3) se_cnt3++;
        end
    end

    task automatic drv1(input logic [3:0] e, input logic [3:0] d, input logic t);
        @(negedge clk);
        en1 = e; d1 = d; dt1 = t;
    endtask

    task automatic drv3(input logic [3:0] e, input logic [3:0] d, input logic t);
        @(negedge clk);
        en3 = e; d3 = d; dt3 = t;
    endtask

    // Three reset edges with a random bus; returns at the release negedge.
    task automatic reset1();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst1 = 1'b1; en1 = 4'($urandom); d1 = 4'($urandom); dt1 = 1'($urandom);
        end
        @(negedge clk);
        rst1 = 1'b0; en1 = 4'hF; d1 = 4'h0; dt1 = 1'b0;
    endtask

    task automatic reset3();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst3 = 1'b1; en3 = 4'($urandom); d3 = 4'($urandom); dt3 = 1'($urandom);
        end
        @(negedge clk);
        rst3 = 1'b0; en3 = 4'hF; d3 = 4'h0; dt3 = 1'b0;
    endtask

    initial begin
        int s0;
        rst1 = 1'b1; rst3 = 1'b1;
        en1 = 4'hF; d1 = 4'h0; dt1 = 1'b0;
        en3 = 4'hF; d3 = 4'h0; dt3 = 1'b0;

        // ---- Reset ----
        fork
            reset1();
            reset3();
        join
        check("rst_digits",  {16'd0, dg1}, 32'd0);
        check("rst_dp",      {28'd0, dp1}, 32'd0);
        check("rst_valid",   {28'd0, vl1}, 32'd0);
        check("rst_timeout", {28'd0, to1}, 32'd0);
        check("rst_upd",     {31'd0, up1}, 32'd0);
        check("rst_upd_idx", {30'd0, ix1}, 32'd0);
        check("rst_scan_err",{31'd0, se1}, 32'd0);
        check("rst3_digits", {16'd0, dg3}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_upd",      {31'd0, up1}, 32'd0);
            check("post_rst_scan_err", {31'd0, se1}, 32'd0);
        end

        // ---- Ping-pong at STABLE_CYC=1 ----
        q1.push_back('{idx: 2'd0, data: 4'h5, dp: 1'b0});
        q1.push_back('{idx: 2'd1, data: 4'hA, dp: 1'b1});
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drv1(4'b1110, 4'h5, 1'b0);
            else            drv1(4'b1101, 4'hA, 1'b1);
        end
        drv1(4'hF, 4'h0, 1'b0);
        drv1(4'hF, 4'h0, 1'b0);
        @(negedge clk);
        check("pp_digits", {16'd0, dg1}, 32'h00A5);
        check("pp_valid",  {28'd0, vl1}, 32'b0011);
        check("pp_dp",     {28'd0, dp1}, 32'b0010);
        check("pp_queue",  q1.size(), 32'd0);

        // ---- Illegal enable, then idle ----
        s0 = se_cnt1;
        drv1(4'b1100, 4'h3, 1'b0);
        drv1(4'b1100, 4'h3, 1'b0);
        drv1(4'hF, 4'h0, 1'b0);
        drv1(4'hF, 4'h0, 1'b0);
        @(negedge clk);
        check("ill_scan_err_cnt", se_cnt1 - s0, 32'd2);
        check("ill_digits", {16'd0, dg1}, 32'h00A5);
        check("ill_valid",  {28'd0, vl1}, 32'b0011);
        s0 = se_cnt1;
        drv1(4'hF, 4'h7, 1'b1);
        drv1(4'hF, 4'h7, 1'b1);
        drv1(4'hF, 4'h7, 1'b1);
        @(negedge clk);
        check("idle_scan_err_cnt", se_cnt1 - s0, 32'd0);
        check("idle_digits", {16'd0, dg1}, 32'h00A5);
        check("idle_dp",     {28'd0, dp1}, 32'b0010);

        // ---- Timeout (TIMEOUT_CYC=16) ----
        // E1 = first edge after release. Digit 2 samples E2, commits E3.
        // Digit 0 commits E4. Digits 1,3 go stale at E16, digit 2 at E19.
        reset1();
        q1.push_back('{idx: 2'd2, data: 4'hC, dp: 1'b0});
        q1.push_back('{idx: 2'd0, data: 4'h5, dp: 1'b0});
        drv1(4'b1011, 4'hC, 1'b0);
        drv1(4'b1110, 4'h5, 1'b0);
        repeat (16) @(negedge clk);
        check("to_pre_valid",   {28'd0, vl1}, 32'b0101);
        check("to_pre_timeout", {28'd0, to1}, 32'b1010);
        @(negedge clk);
        check("to_valid",   {28'd0, vl1}, 32'b0001);
        check("to_timeout", {28'd0, to1}, 32'b1110);
        check("to_digits",  {16'd0, dg1}, 32'h0C05);
        // Re-commit digit 2 with a new value, then again with the same value.
        q1.push_back('{idx: 2'd2, data: 4'hD, dp: 1'b0});
        drv1(4'b1011, 4'hD, 1'b0);
        drv1(4'hF, 4'h0, 1'b0);
        drv1(4'b1011, 4'hD, 1'b0);
        drv1(4'hF, 4'h0, 1'b0);
        drv1(4'hF, 4'h0, 1'b0);
        @(negedge clk);
        check("recommit_timeout", {28'd0, to1}, 32'b1011);
        check("recommit_valid",   {28'd0, vl1}, 32'b0100);
        check("recommit_digits",  {16'd0, dg1}, 32'h0D05);
        check("recommit_queue",   q1.size(), 32'd0);

        // ---- Glitch rejection at STABLE_CYC=3 ----
        drv3(4'b1110, 4'h7, 1'b0);
        drv3(4'b1110, 4'h7, 1'b0);
        q3.push_back('{idx: 2'd0, data: 4'h9, dp: 1'b0});
        drv3(4'b1110, 4'h9, 1'b0);
        drv3(4'b1110, 4'h9, 1'b0);
        drv3(4'b1110, 4'h9, 1'b0);
        drv3(4'hF, 4'h0, 1'b0);
        check("gl_before_commit", {28'd0, dg3[3:0]}, 32'h0);
        @(negedge clk);
        check("gl_commit_digit", {28'd0, dg3[3:0]}, 32'h9);
        check("gl_commit_valid", {28'd0, vl3}, 32'b0001);

        // ---- Reset mid-dwell at STABLE_CYC=3 ----
        drv3(4'b1101, 4'h3, 1'b0);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        check("mid_rst_digits", {16'd0, dg3}, 32'd0);
        check("mid_rst_valid",  {28'd0, vl3}, 32'd0);
        q3.push_back('{idx: 2'd1, data: 4'h3, dp: 1'b0});
        repeat (3) @(negedge clk);
        check("mid_rst_no_early", {28'd0, dg3[7:4]}, 32'h0);
        @(negedge clk);
        check("mid_rst_commit", {28'd0, dg3[7:4]}, 32'h3);
        en3 = 4'hF;

        repeat (4) @(negedge clk);
        check("final_q1_empty", q1.size(), 32'd0);
        check("final_q3_empty", q3.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
